// File: rtl/cl_decode_queue_pkg.sv
// Shared decode types, widths and elaboration helpers for cl_decode_queue.
// Optional perf counters in the top are enabled by CL_DECODE_PERF_EN.
package cl_decode_queue_pkg;

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_LW   = 5'd1,
        OP_LBU  = 5'd2,
        OP_SW   = 5'd3,
        OP_SB   = 5'd4,
        OP_ADDU = 5'd5,
        OP_SUBU = 5'd6,
        OP_SLLV = 5'd7,
        OP_SRAV = 5'd8,
        OP_SRLV = 5'd9,
        OP_AND  = 5'd10,
        OP_OR   = 5'd11,
        OP_NOR  = 5'd12,
        OP_SLT  = 5'd13,
        OP_SLTU = 5'd14,
        OP_MOV  = 5'd15,
        OP_JALR = 5'd16,
        OP_BRLU = 5'd17,
        OP_BEQ  = 5'd18,
        OP_J    = 5'd19
    } opcode_e;

    typedef struct packed {
        opcode_e     op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [11:0] imm;
    } instruction_s;

    localparam int INSTR_W = $bits(instruction_s);

    typedef struct packed {
        instruction_s instr;
        logic         is_load;
        logic         is_store;
        logic         is_mem;
        logic         is_byte;
        logic         op_writes_rf;
    } decode_s;

    localparam int DECODE_W = $bits(decode_s);

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    // Flags that feed the perf counters: {load, store, rf write}
    function automatic logic [2:0] perf_bits(input decode_s d);
        return {d.is_load, d.is_store, d.op_writes_rf};
    endfunction

endpackage

// File: rtl/cl_decode_comb.sv
// Purely combinational instruction_s -> decode_s mapping.
module cl_decode_comb
    import cl_decode_queue_pkg::*;
(
    input  logic [INSTR_W-1:0]  instruction,
    output logic [DECODE_W-1:0] decode
);

    instruction_s ins;
    decode_s      d;

    assign ins = instruction_s'(instruction);

    always_comb begin
        d       = '0;
        d.instr = ins;
        unique case (ins.op)
            OP_LW: begin
                d.is_load      = 1'b1;
                d.is_mem       = 1'b1;
                d.op_writes_rf = 1'b1;
            end
            OP_LBU: begin
                d.is_load      = 1'b1;
                d.is_mem       = 1'b1;
                d.is_byte      = 1'b1;
                d.op_writes_rf = 1'b1;
            end
            OP_SW: begin
                d.is_store = 1'b1;
                d.is_mem   = 1'b1;
            end
            OP_SB: begin
                d.is_store = 1'b1;
                d.is_mem   = 1'b1;
                d.is_byte  = 1'b1;
            end
            OP_ADDU, OP_SUBU, OP_SLLV, OP_SRAV, OP_SRLV,
            OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLTU,
            OP_MOV, OP_JALR, OP_BRLU: begin
                d.op_writes_rf = 1'b1;
            end
            default: ;
        endcase
    end

    assign decode = d;

endmodule

// File: rtl/cl_decode_queue.sv
// Registered decode stage: decodes at enqueue into a DEPTH-entry FIFO.
// Define CL_DECODE_PERF_EN to add per-class dequeue counters.
module cl_decode_queue
    import cl_decode_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush_i,
    input  logic                      valid_i,
    input  logic [INSTR_W-1:0]        instruction_i,
    output logic                      ready_o,
    output logic                      valid_o,
    output logic [DECODE_W-1:0]       decode_o,
    input  logic                      ready_i,
    output logic [$clog2(DEPTH):0]    count_o
`ifdef CL_DECODE_PERF_EN
    ,
    output logic [CNT_W-1:0]          n_load_o,
    output logic [CNT_W-1:0]          n_store_o,
    output logic [CNT_W-1:0]          n_rf_wr_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    if (!is_pow2(DEPTH) || DEPTH < 2 || CNT_W < 1) begin : g_bad_cfg
        $error("cl_decode_queue: DEPTH must be a power of two >= 2");
    end

    logic [DECODE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wptr;
    logic [PTR_W-1:0]    rptr;
    logic [PTR_W:0]      count;
    logic [DECODE_W-1:0] wdata;
    logic                full;
    logic                empty;
    logic                enq;
    logic                deq;

    cl_decode_comb u_comb (
        .instruction (instruction_i),
        .decode      (wdata)
    );

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign ready_o  = ~full;
    assign valid_o  = ~empty;
    assign count_o  = count;
    assign decode_o = empty ? '0 : mem[rptr];

    // Flush wins over both handshakes in the same cycle
    assign enq = valid_i & ~full & ~flush_i;
    assign deq = ~empty & ready_i & ~flush_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (deq) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CL_DECODE_PERF_EN
    logic [2:0]       hit;
    logic [CNT_W-1:0] n_load;
    logic [CNT_W-1:0] n_store;
    logic [CNT_W-1:0] n_rf_wr;

    assign hit = perf_bits(decode_s'(decode_o));

    // Counters survive flush; only reset clears them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_load  <= '0;
            n_store <= '0;
            n_rf_wr <= '0;
        end else if (deq) begin
            if (hit[2]) n_load  <= n_load + 1'b1;
            if (hit[1]) n_store <= n_store + 1'b1;
            if (hit[0]) n_rf_wr <= n_rf_wr + 1'b1;
        end
    end

    assign n_load_o  = n_load;
    assign n_store_o = n_store;
    assign n_rf_wr_o = n_rf_wr;
`endif

endmodule

// File: tb/tb_cl_decode_queue.sv
// Scoreboard bench for cl_decode_queue (DEPTH=2, CNT_W=4).
// Counter checks run when CL_DECODE_PERF_EN is defined.
module tb_cl_decode_queue;
    import cl_decode_queue_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                flush_i;
    logic                valid_i;
    logic [INSTR_W-1:0]  instruction_i;
    logic                ready_o;
    logic                valid_o;
    logic [DECODE_W-1:0] decode_o;
    logic                ready_i;
    logic [1:0]          count_o;
`ifdef CL_DECODE_PERF_EN
    logic [3:0]          n_load_o;
    logic [3:0]          n_store_o;
    logic [3:0]          n_rf_wr_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [DECODE_W-1:0] sb [$];

    always #5 clk = ~clk;

    cl_decode_queue #(.DEPTH(2), .CNT_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush_i),
        .valid_i       (valid_i),
        .instruction_i (instruction_i),
        .ready_o       (ready_o),
        .valid_o       (valid_o),
        .decode_o      (decode_o),
        .ready_i       (ready_i),
        .count_o       (count_o)
`ifdef CL_DECODE_PERF_EN
        ,
        .n_load_o      (n_load_o),
        .n_store_o     (n_store_o),
        .n_rf_wr_o     (n_rf_wr_o)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic instruction_s mki(input opcode_e op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [11:0] imm);
        instruction_s i;
        i.op  = op;
        i.rd  = rd;
        i.rs  = rs;
        i.rt  = 5'd7;
        i.imm = imm;
        return i;
    endfunction

    function automatic logic [DECODE_W-1:0] mkexp(input instruction_s i, input bit ld,
                                                  input bit st, input bit mm,
                                                  input bit by, input bit wr);
        decode_s d;
        d.instr        = i;
        d.is_load      = ld;
        d.is_store     = st;
        d.is_mem       = mm;
        d.is_byte      = by;
        d.op_writes_rf = wr;
        return d;
    endfunction

    // Monitor: checks every dequeued head against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (valid_o && ready_i && !flush_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL deq_unexpected: got %h required none", decode_o);
                end else begin
                    chk("deq_data", 64'(decode_o), 64'(sb.pop_front()));
                end
            end else if (!valid_o) begin
                chk("idle_zero", 64'(decode_o), 64'd0);
            end
        end
    end

    task automatic step(input logic v, input instruction_s ins, input logic f,
                        input logic r, input logic [DECODE_W-1:0] e);
        valid_i       = v;
        instruction_i = ins;
        flush_i       = f;
        ready_i       = r;
        @(negedge clk);
        if (f) sb.delete();
        else if (v && ready_o) sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        instruction_s i_lw, i_lbu, i_sw, i_sb, i_addu, i_unk, i_z;
        logic [DECODE_W-1:0] e_lw, e_lbu, e_sw, e_sb, e_addu, e_unk;

        i_lw   = mki(OP_LW,   5'd1, 5'd2, 12'h010);
        i_lbu  = mki(OP_LBU,  5'd3, 5'd4, 12'h021);
        i_sw   = mki(OP_SW,   5'd5, 5'd6, 12'h032);
        i_sb   = mki(OP_SB,   5'd8, 5'd9, 12'h043);
        i_addu = mki(OP_ADDU, 5'd10, 5'd11, 12'h000);
        i_unk  = mki(OP_NOP,  5'd12, 5'd13, 12'h5a5);
        i_unk.op = opcode_e'(5'd31);
        i_z    = '0;

        e_lw   = mkexp(i_lw,   1, 0, 1, 0, 1);
        e_lbu  = mkexp(i_lbu,  1, 0, 1, 1, 1);
        e_sw   = mkexp(i_sw,   0, 1, 1, 0, 0);
        e_sb   = mkexp(i_sb,   0, 1, 1, 1, 0);
        e_addu = mkexp(i_addu, 0, 0, 0, 0, 1);
        e_unk  = mkexp(i_unk,  0, 0, 0, 0, 0);

        reset = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        instruction_i = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_decode", 64'(decode_o), 64'd0);
        reset = 1'b0;

        // LW appears one cycle after being offered
        step(1, i_lw, 0, 1, e_lw);
        chk("lw_valid", 64'(valid_o), 64'd1);
        chk("lw_head", 64'(decode_o), 64'(e_lw));
        chk("lw_count", 64'(count_o), 64'd1);
        step(0, i_z, 0, 1, '0);
        chk("lw_drained", 64'(count_o), 64'd0);

        // Fill with back-pressure; SW held off
        step(1, i_sb, 0, 0, e_sb);
        step(1, i_addu, 0, 0, e_addu);
        chk("full_count", 64'(count_o), 64'd2);
        chk("full_ready", 64'(ready_o), 64'd0);
        step(1, i_sw, 0, 0, e_sw);
        chk("held_count", 64'(count_o), 64'd2);
        chk("held_head", 64'(decode_o), 64'(e_sb));

        // Stream out of full; SW accepted once space appears
        step(1, i_sw, 0, 1, e_sw);
        chk("stream_cnt1", 64'(count_o), 64'd1);
        chk("stream_ready", 64'(ready_o), 64'd1);
        step(1, i_sw, 0, 1, e_sw);
        chk("simul_count", 64'(count_o), 64'd1);
        chk("simul_head", 64'(decode_o), 64'(e_sw));
        step(0, i_z, 0, 1, '0);
        chk("stream_empty", 64'(count_o), 64'd0);

        // Flush beats enq and deq
        step(1, i_lw, 0, 0, e_lw);
        step(1, i_addu, 1, 1, e_addu);
        chk("flush_count", 64'(count_o), 64'd0);
        chk("flush_valid", 64'(valid_o), 64'd0);
        chk("flush_decode", 64'(decode_o), 64'd0);

        // Unknown opcode still queued with no flags
        step(1, i_unk, 0, 0, e_unk);
        chk("unk_valid", 64'(valid_o), 64'd1);
        chk("unk_head", 64'(decode_o), 64'(e_unk));

        // Async reset pulse mid-cycle
        valid_i = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("areset_valid", 64'(valid_o), 64'd0);
        chk("areset_ready", 64'(ready_o), 64'd1);
        chk("areset_count", 64'(count_o), 64'd0);
        chk("areset_decode", 64'(decode_o), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1, i_addu, 0, 1, e_addu);
        chk("recover_head", 64'(decode_o), 64'(e_addu));
        step(0, i_z, 0, 1, '0);
        chk("recover_count", 64'(count_o), 64'd0);

`ifdef CL_DECODE_PERF_EN
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("perf_rst_load", 64'(n_load_o), 64'd0);
        chk("perf_rst_rf", 64'(n_rf_wr_o), 64'd0);
        step(1, i_sw, 0, 0, e_sw);
        step(1, i_lbu, 1, 1, e_lbu);
        chk("perf_flush_store", 64'(n_store_o), 64'd0);
        for (int k = 0; k < 17; k++) begin
            step(1, i_lbu, 0, 1, e_lbu);
        end
        for (int k = 0; k < 8 && count_o != 0; k++) begin
            step(0, i_z, 0, 1, '0);
        end
        chk("perf_drained", 64'(count_o), 64'd0);
        chk("perf_load_wrap", 64'(n_load_o), 64'd1);
        chk("perf_rf_wrap", 64'(n_rf_wr_o), 64'd1);
        chk("perf_store", 64'(n_store_o), 64'd0);
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
